rx_line_collector: RTL

Receive-side companion to the UART transmit driver. It accepts bytes from the UART receiver one strobe at a time and assembles them into a line buffer. A line ends on a terminator byte or when the buffer fills. The completed line is held for a downstream consumer, which reads it back by address and releases it with an acknowledge.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/rx_line_collector_line_buffer.sv | 34 +++
 rtl/rx_line_collector.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by both directions of the UART path.
//   rx_state_t : receive line collector states (RX_COLLECT, RX_HOLD)
//   tx_state_t : transmit driver states (TX_IDLE, TX_START, TX_DATA, TX_STOP)
//   ASCII_LF   : line feed, the default end-of-line byte
//   ASCII_CR   : carriage return, optionally stripped on receive
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef enum logic {
        RX_COLLECT,
        RX_HOLD
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage : uart_pkg

// File: rtl/rx_line_collector_line_buffer.sv
// ---------------------------------------------------------------------------
// line_buffer
// Simple dual-port RAM, 8 bits x DEPTH, one write port and one registered
// read port. Contents are not reset.
// Ports:
//   clk     in   clock, all activity on posedge
//   wr_en   in   write strobe
//   wr_addr in   write address
//   wr_data in   write byte
//   rd_addr in   read address
//   rd_data out  registered byte at rd_addr (old data on a same-address write)
// ---------------------------------------------------------------------------
module line_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule : line_buffer

// File: rtl/rx_line_collector.sv
// ---------------------------------------------------------------------------
// rx_line_collector
// Assembles received UART bytes into a line buffer. A line completes on the
// terminator byte or when the buffer fills, and is then held until the
// consumer acknowledges it. Bytes arriving while a line is held are dropped
// and recorded in the sticky Overflow flag.
// Optional build macro:
//   RX_CR_STRIP_EN : when defined, 8'h0D is discarded while collecting
//                    (still sets Overflow while a line is held).
// Ports:
//   Clock      in   system clock, posedge
//   Reset      in   asynchronous active-low reset
//   RxReady    in   one-cycle strobe, RxData valid
//   RxData     in   received byte
//   LineReady  out  high while a completed line is held
//   LineLength out  byte count of the held line (terminator excluded)
//   ReadAddr   in   consumer read address
//   ReadData   out  registered byte at ReadAddr, 0 beyond LineLength
//   LineAck    in   consumer releases the held line
//   Overflow   out  sticky, a byte was dropped while a line was held
// ---------------------------------------------------------------------------
module rx_line_collector
    import uart_pkg::*;
#(
    parameter int         MAX_LEN    = 16,
    parameter logic [7:0] TERMINATOR = ASCII_LF
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           RxReady,
    input  logic [7:0]                     RxData,
    output logic                           LineReady,
    output logic [$clog2(MAX_LEN+1)-1:0]   LineLength,
    input  logic [$clog2(MAX_LEN)-1:0]     ReadAddr,
    output logic [7:0]                     ReadData,
    input  logic                           LineAck,
    output logic                           Overflow
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int CW = $clog2(MAX_LEN + 1);

    rx_state_t      state;
    rx_state_t      state_next;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic [CW-1:0]  length;
    logic [CW-1:0]  length_next;
    logic           overflow;
    logic           overflow_next;
    logic           wr_en;
    logic           rd_valid;
    logic [7:0]     buf_data;
    logic           is_strip;

`ifdef RX_CR_STRIP_EN
    assign is_strip = (RxData == ASCII_CR);
`else
    assign is_strip = 1'b0;
`endif

    // State, counters and flags. Reset clears everything but the RAM, so a
    // partial line vanishes the moment Reset goes low.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= RX_COLLECT;
            count    <= '0;
            length   <= '0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            length   <= length_next;
            overflow <= overflow_next;
            rd_valid <= (CW'(ReadAddr) < length);
        end
    end

    // Next-state logic. The terminator is checked before the CR strip so a
    // terminator always ends the line. In RX_HOLD every strobe is dropped,
    // including one coinciding with LineAck.
    always_comb begin
        state_next    = state;
        count_next    = count;
        length_next   = length;
        overflow_next = overflow;
        wr_en         = 1'b0;

        case (state)
            RX_COLLECT: begin
                if (RxReady) begin
                    if (RxData == TERMINATOR) begin
                        if (count != '0) begin
                            length_next = count;
                            state_next  = RX_HOLD;
                        end
                    end else if (!is_strip) begin
                        wr_en      = 1'b1;
                        count_next = count + CW'(1);
                        if (count_next == CW'(MAX_LEN)) begin
                            length_next = CW'(MAX_LEN);
                            state_next  = RX_HOLD;
                        end
                    end
                end
            end
            RX_HOLD: begin
                if (RxReady) begin
                    overflow_next = 1'b1;
                end
                if (LineAck) begin
                    count_next  = '0;
                    length_next = '0;
                    state_next  = RX_COLLECT;
                end
            end
            default: begin
                state_next = RX_COLLECT;
            end
        endcase
    end

    line_buffer #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_line_buffer (
        .clk     (Clock),
        .wr_en   (wr_en),
        .wr_addr (AW'(count)),
        .wr_data (RxData),
        .rd_addr (ReadAddr),
        .rd_data (buf_data)
    );

    // The RAM output is not reset, so it is masked by a resettable valid
    // flag captured alongside the read address.
    assign ReadData   = rd_valid ? buf_data : 8'h00;
    assign LineReady  = (state == RX_HOLD);
    assign LineLength = length;
    assign Overflow   = overflow;

endmodule : rx_line_collector
